// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: HD44780 character LCD write controller with autonomous power-up init.
// Each byte is strobed with setup/pulse/hold timing, then the LCD execution time is waited out.
module lcd_char_ctrl #(
    parameter int POWERUP_CYC = 750000,
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 12,
    parameter int HOLD_CYC    = 2,
    parameter int CMD_CYC     = 2000,
    parameter int CLEAR_CYC   = 82000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_RS,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic       LCD_BLON
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXC = max2(max2(max2(POWERUP_CYC, SETUP_CYC), max2(PULSE_CYC, HOLD_CYC)),
                               max2(CMD_CYC, CLEAR_CYC));
    localparam int CW = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {PWRUP, LOAD, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_idx;
    logic [7:0]      r_data;
    logic            r_rs;
    logic            r_en;
    logic            r_on;
    logic            r_ready;
    logic            r_init;
    logic [CW-1:0]   w_lim;
    logic            w_done;
    logic            w_clear;
    logic [1:0]      w_nidx;
    logic [7:0]      w_rom;

    assign w_clear = !r_rs && (r_data[7:2] == 6'd0) && (r_data[1:0] != 2'd0);
    assign w_nidx  = r_idx + 2'd1;
    assign w_rom   = (w_nidx == 2'd1) ? 8'h0C : (w_nidx == 2'd2) ? 8'h01 : 8'h06;

    always_comb begin
        w_lim = '0;
        case (r_state)
            PWRUP:   w_lim = CW'(POWERUP_CYC - 1);
            SETUP:   w_lim = CW'(SETUP_CYC - 1);
            PULSE:   w_lim = CW'(PULSE_CYC - 1);
            HOLD:    w_lim = CW'(HOLD_CYC - 1);
            WAIT:    w_lim = w_clear ? CW'(CLEAR_CYC - 1) : CW'(CMD_CYC - 1);
            default: w_lim = '0;
        endcase
    end

    assign w_done = (r_cnt == w_lim);

    // LOAD counts as the first setup cycle, so init writes and user writes share timing
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= PWRUP;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_rs    <= 1'b0;
            r_en    <= 1'b0;
            r_on    <= 1'b0;
            r_ready <= 1'b0;
            r_init  <= 1'b0;
        end else begin
            r_on  <= 1'b1;
            r_cnt <= r_cnt + CW'(1);
            case (r_state)
                PWRUP: if (w_done) begin
                    r_state <= LOAD;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_rs    <= 1'b0;
                    r_data  <= 8'h38;
                end
                LOAD: begin
                    r_state <= (SETUP_CYC > 1) ? SETUP : PULSE;
                    r_cnt   <= CW'(SETUP_CYC > 1);
                    r_en    <= (SETUP_CYC == 1);
                end
                SETUP: if (w_done) begin
                    r_state <= PULSE;
                    r_cnt   <= '0;
                    r_en    <= 1'b1;
                end
                PULSE: if (w_done) begin
                    r_state <= HOLD;
                    r_cnt   <= '0;
                    r_en    <= 1'b0;
                end
                HOLD: if (w_done) begin
                    r_state <= WAIT;
                    r_cnt   <= '0;
                end
                WAIT: if (w_done) begin
                    r_cnt <= '0;
                    if (r_init || r_idx == 2'd3) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_init  <= 1'b1;
                    end else begin
                        r_state <= LOAD;
                        r_idx   <= w_nidx;
                        r_rs    <= 1'b0;
                        r_data  <= w_rom;
                    end
                end
                IDLE: begin
                    r_cnt <= '0;
                    if (wr_valid && r_ready) begin
                        r_state <= SETUP;
                        r_rs    <= wr_rs;
                        r_data  <= wr_data;
                        r_ready <= 1'b0;
                    end
                end
                default: r_state <= PWRUP;
            endcase
        end
    end

    assign wr_ready  = r_ready;
    assign init_done = r_init;
    assign LCD_DATA  = r_data;
    assign LCD_RS    = r_rs;
    assign LCD_EN    = r_en;
    assign LCD_RW    = 1'b0;
    assign LCD_ON    = r_on;
    assign LCD_BLON  = r_on;
endmodule

// File: tb/tb_lcd_char_ctrl.sv
// tb_lcd_char_ctrl: scoreboard bench; driver queues expected bytes/occupancy, monitor checks EN strobes.
module tb_lcd_char_ctrl;
    localparam int PWR = 20, SET = 2, PUL = 4, HLD = 2, CMD = 10, CLR = 30;
    localparam int INIT = PWR + 3 * (SET + PUL + HLD + CMD) + (SET + PUL + HLD + CLR);

    logic       clk = 0, rst_n = 0, wr_valid = 0, wr_rs = 0;
    logic [7:0] wr_data = 0;
    logic       wr_ready, init_done, LCD_RW, LCD_RS, LCD_EN, LCD_ON, LCD_BLON;
    logic [7:0] LCD_DATA;

    int checks = 0, fails = 0, cyc = 0, rel_cyc = 0, acc_cyc = 0;
    logic [8:0] exp_q[$];
    int         occ_q[$];

    lcd_char_ctrl #(.POWERUP_CYC(PWR), .SETUP_CYC(SET), .PULSE_CYC(PUL), .HOLD_CYC(HLD),
                    .CMD_CYC(CMD), .CLEAR_CYC(CLR)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_rs(wr_rs), .wr_data(wr_data), .init_done(init_done), .LCD_DATA(LCD_DATA),
        .LCD_RW(LCD_RW), .LCD_RS(LCD_RS), .LCD_EN(LCD_EN), .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", n, a, e, cyc);
        end
    endtask

    task automatic bad(input string n);
        checks++;
        fails++;
        $display("FAIL %s: got timeout/empty expected event at cycle %0d", n, cyc);
    endtask

    function automatic int occ(input logic rs, input logic [7:0] d);
        return SET + PUL + HLD + ((!rs && d >= 8'h01 && d <= 8'h03) ? CLR : CMD);
    endfunction

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endtask

    task automatic wr(input logic rs, input logic [7:0] d, input logic hold);
        bit ok = 0;
        exp_q.push_back({rs, d});
        occ_q.push_back(occ(rs, d));
        @(negedge clk);
        wr_valid = 1;
        wr_rs = rs;
        wr_data = d;
        for (int i = 0; i < 300; i++) begin
            if (wr_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) bad("accept_timeout");
        else begin
            @(posedge clk);
            #1 acc_cyc = cyc;
        end
        if (!hold) wr_valid = 0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && occ_q.size() == 0 && wr_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bad("drain_timeout");
        chk("queues_empty", exp_q.size() + occ_q.size(), 0);
    endtask

    logic       pen = 0, prdy = 0, acc_pend = 0;
    logic [8:0] h1 = 0, h2 = 0, pval = 0;
    int         rise_c = 0, hold_left = 0, acc_c = 0;

    always @(negedge clk) begin
        logic [8:0] cur;
        cur = {LCD_RS, LCD_DATA};
        if (!rst_n) begin
            pen = 0; prdy = 0; acc_pend = 0; h1 = 0; h2 = 0; hold_left = 0;
        end else begin
            if (LCD_EN && !pen) begin
                rise_c = cyc;
                if (exp_q.size() == 0) bad("unexpected_pulse");
                else chk("pulse_byte", cur, exp_q.pop_front());
                chk("setup_stable", {h2, h1}, {cur, cur});
                chk("on_blon_rw", {LCD_ON, LCD_BLON, LCD_RW}, 3'b110);
            end
            if (!LCD_EN && pen) begin
                chk("pulse_width", cyc - rise_c, PUL);
                pval = h1;
                hold_left = HLD;
            end
            if (hold_left > 0) begin
                chk("hold_stable", cur, pval);
                hold_left--;
            end
            if (!wr_ready && prdy) begin
                acc_pend = 1;
                acc_c = cyc;
            end
            if (wr_ready && !prdy) begin
                if (acc_pend) begin
                    if (occ_q.size() == 0) bad("unexpected_ready");
                    else chk("busy_cycles", cyc - acc_c, occ_q.pop_front());
                    acc_pend = 0;
                end else chk("init_cycles", cyc - rel_cyc, INIT);
                chk("init_done_at_ready", init_done, 1);
            end
            h2 = h1; h1 = cur; pen = LCD_EN; prdy = wr_ready;
        end
    end

    initial begin
        bit ok;
        logic [7:0] d;
        logic rs;
        repeat (3) @(negedge clk);
        chk("reset_state", {LCD_EN, LCD_RS, LCD_RW, LCD_DATA, LCD_ON, LCD_BLON, wr_ready, init_done}, 0);
        push_init();
        wr_rs = 1; wr_data = 8'h55; wr_valid = 1;
        rst_n = 1;
        rel_cyc = cyc;
        wr(1, 8'h55, 0);
        chk("first_idle_accept", acc_cyc - rel_cyc, INIT + 1);
        wr(1, 8'h41, 0);
        wr(1, 8'h48, 1);
        wr(1, 8'h49, 1);
        wr(1, 8'h21, 0);
        wr(0, 8'h01, 0);
        wr(0, 8'h80, 0);
        wr(1, 8'h01, 0);
        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
            wr(rs, d, (i < 15) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        drain();
        wr(1, 8'h33, 0);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (LCD_EN) begin
                ok = 1;
                break;
            end
        end
        if (!ok) bad("en_timeout");
        #1 rst_n = 0;
        #1 chk("async_reset", {LCD_EN, LCD_DATA, wr_ready, init_done}, 0);
        exp_q.delete();
        occ_q.delete();
        repeat (2) @(negedge clk);
        push_init();
        rst_n = 1;
        rel_cyc = cyc;
        wr(1, 8'h5A, 0);
        chk("reinit_accept", acc_cyc - rel_cyc, INIT + 1);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
